conv1_mem_read: RTL and testbench

- Read-side addresser for the Convolution 1 layer, directly upstream of the conv1 output write addresser.
- Walks a KxK window across the single-channel input image memory and generates, once per step:
  - the input image read address;
  - the kernel weight read address;
  - accumulator control strobes for the conv1 MAC.
- One output pixel is produced per K*K steps. This matches the write side, which advances its address every 25 cycles.
- Default geometry: 16x16 input, 5x5 kernel, 12x12 output. That is 144 windows and 3600 steps.

---
 rtl/conv1_mem_read.sv | 114 +++++++++++
 tb/tb_conv1_mem_read.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_mem_read.sv
// Read-side addresser for conv1: walks a KxK window over the input image and
// emits image/weight read addresses plus MAC clear/last strobes, one tap per step.
module conv1_mem_read #(
    parameter int IMG_W  = 16,
    parameter int K      = 5,
    parameter int OUT_W  = 12,
    parameter int IMG_AW = 8,
    parameter int WGT_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [IMG_AW-1:0] img_addr,
    output logic [WGT_AW-1:0] wgt_addr,
    output logic              mac_clear,
    output logic              mac_last,
    output logic              done
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int OW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [KW-1:0] kx_q, kx_d;
    logic [KW-1:0] ky_q, ky_d;
    logic [OW-1:0] ox_q, ox_d;
    logic [OW-1:0] oy_q, oy_d;
    logic          done_q;

    logic last_kx, last_ky, last_ox, last_oy;
    logic final_step;

    assign last_kx    = (kx_q == K_LAST);
    assign last_ky    = (ky_q == K_LAST);
    assign last_ox    = (ox_q == O_LAST);
    assign last_oy    = (oy_q == O_LAST);
    assign final_step = last_kx && last_ky && last_ox && last_oy;

    // Odometer-style carry chain: kx -> ky -> ox -> oy.
    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (!last_kx) begin
            kx_d = kx_q + KW'(1);
        end else begin
            kx_d = '0;
            if (!last_ky) begin
                ky_d = ky_q + KW'(1);
            end else begin
                ky_d = '0;
                if (!last_ox) begin
                    ox_d = ox_q + OW'(1);
                end else begin
                    ox_d = '0;
                    oy_d = oy_q + OW'(1);
                end
            end
        end
    end

    // The final step leaves the counters parked so the last addresses stay visible.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            kx_q    <= '0;
            ky_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (enable) begin
                        if (final_step) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            kx_q    <= kx_d;
                            ky_q    <= ky_d;
                            ox_q    <= ox_d;
                            oy_q    <= oy_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Full 32-bit arithmetic, truncated; parameter constraints rule out overflow.
    assign img_addr = IMG_AW'((32'(oy_q) + 32'(ky_q)) * 32'(IMG_W) + 32'(ox_q) + 32'(kx_q));
    assign wgt_addr = WGT_AW'(32'(ky_q) * 32'(K) + 32'(kx_q));

    assign mac_clear = (state_q != S_DONE) && (kx_q == '0) && (ky_q == '0);
    assign mac_last  = (state_q != S_DONE) && last_kx && last_ky;
    assign done      = done_q;

endmodule

// File: tb/tb_conv1_mem_read.sv
// Directed bench for conv1_mem_read: reset, first window, row wrap, completion,
// pause handling and asynchronous mid-run reset.
module tb_conv1_mem_read;

    localparam int TOTAL = 3600;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] img_addr;
    logic [4:0] wgt_addr;
    logic       mac_clear;
    logic       mac_last;
    logic       done;

    logic [15:0] obs;
    logic [15:0] exp_v;
    int          vectors = 0;
    int          errors = 0;
    int          pos = 0;

    conv1_mem_read #(
        .IMG_W (16),
        .K     (5),
        .OUT_W (12),
        .IMG_AW(8),
        .WGT_AW(5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .img_addr (img_addr),
        .wgt_addr (wgt_addr),
        .mac_clear(mac_clear),
        .mac_last (mac_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    assign obs = {img_addr, wgt_addr, mac_clear, mac_last, done};

    // Reference model from the flat step count: {img, wgt, clear, last, done}.
    function automatic logic [15:0] exp_vec(input int p);
        int tap, win, kx, ky, ox, oy, ia;
        logic [7:0] ia8;
        logic [4:0] wa5;
        if (p >= TOTAL) return {8'd255, 5'd24, 1'b0, 1'b0, 1'b1};
        tap = p % 25;
        win = p / 25;
        kx  = tap % 5;
        ky  = tap / 5;
        ox  = win % 12;
        oy  = win / 12;
        ia  = (oy + ky) * 16 + ox + kx;
        ia8 = ia[7:0];
        wa5 = tap[4:0];
        return {ia8, wa5, (tap == 0), (tap == 24), 1'b0};
    endfunction

    // One falling (active) edge, then sample just after the following rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        reset  = 1'b0;
        pos    = 0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        tick();
        tick();
        vectors++;
        if (obs !== 16'b0000_0000_00000_1_0_0) begin
            errors++;
            $display("FAIL reset_vals got=%h exp=%h", obs, 16'b0000_0000_00000_1_0_0);
        end
        reset  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (obs !== 16'b0000_0000_00000_1_0_0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, 16'b0000_0000_00000_1_0_0);
            end
        end
        pos = 0;
    endtask

    task automatic test_first_window();
        logic [7:0] img_tbl [25];
        logic [4:0] w;
        img_tbl = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4,
                    8'd16, 8'd17, 8'd18, 8'd19, 8'd20,
                    8'd32, 8'd33, 8'd34, 8'd35, 8'd36,
                    8'd48, 8'd49, 8'd50, 8'd51, 8'd52,
                    8'd64, 8'd65, 8'd66, 8'd67, 8'd68};
        for (int i = 0; i < 25; i++) begin
            w = 5'(i);
            exp_v = {img_tbl[i], w, (i == 0), (i == 24), 1'b0};
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL first_window tap=%0d got=%h exp=%h", i, obs, exp_v);
            end
            enable = 1'b1;
            tick();
            pos++;
        end
        vectors++;
        if (obs !== {8'd1, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL second_window_start got=%h exp=%h", obs, {8'd1, 5'd0, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_row_wrap();
        enable = 1'b1;
        while (pos < 300) begin
            tick();
            pos++;
            exp_v = exp_vec(pos);
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL row_wrap_seq pos=%0d got=%h exp=%h", pos, obs, exp_v);
            end
        end
        vectors++;
        if (obs !== {8'd16, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL row_wrap_w12 got=%h exp=%h", obs, {8'd16, 5'd0, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_completion();
        enable = 1'b1;
        while (pos < TOTAL) begin
            tick();
            pos++;
            exp_v = exp_vec(pos);
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL run_seq pos=%0d got=%h exp=%h", pos, obs, exp_v);
            end
            if (pos == 3575) begin
                vectors++;
                if (obs !== {8'd187, 5'd0, 1'b1, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL last_window_start got=%h exp=%h", obs, {8'd187, 5'd0, 1'b1, 1'b0, 1'b0});
                end
            end
            if (pos == 3599) begin
                vectors++;
                if (obs !== {8'd255, 5'd24, 1'b0, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL last_tap got=%h exp=%h", obs, {8'd255, 5'd24, 1'b0, 1'b1, 1'b0});
                end
            end
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            vectors++;
            if (obs !== {8'd255, 5'd24, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL done_hold cyc=%0d got=%h exp=%h", i, obs, {8'd255, 5'd24, 1'b0, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_pause();
        bit paused = 1'b0;
        pulse_reset();
        for (int cyc = 0; cyc < 1500 && pos < 450; cyc++) begin
            if (pos == 17 && !paused) begin
                paused = 1'b1;
                enable = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    tick();
                    vectors++;
                    if (obs !== {8'd50, 5'd17, 1'b0, 1'b0, 1'b0}) begin
                        errors++;
                        $display("FAIL pause_mid_window cyc=%0d got=%h exp=%h", j, obs, {8'd50, 5'd17, 1'b0, 1'b0, 1'b0});
                    end
                end
            end else begin
                enable = 1'($urandom_range(0, 1));
                tick();
                if (enable) pos++;
                exp_v = exp_vec(pos);
                vectors++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL pause_seq pos=%0d en=%0b got=%h exp=%h", pos, enable, obs, exp_v);
                end
            end
        end
        vectors++;
        if (!paused) begin
            errors++;
            $display("FAIL pause_reached got=%0b exp=%0b", paused, 1'b1);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_reset();
        enable = 1'b1;
        while (pos < 1000) begin
            tick();
            pos++;
        end
        exp_v = exp_vec(1000);
        vectors++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pre_reset_pos got=%h exp=%h", obs, exp_v);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (obs !== {8'd0, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", obs, {8'd0, 5'd0, 1'b1, 1'b0, 1'b0});
        end
        tick();
        reset = 1'b0;
        pos   = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            pos++;
            exp_v = exp_vec(pos);
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rerun_seq pos=%0d got=%h exp=%h", pos, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_row_wrap();
        test_completion();
        test_pause();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time=%0t limit=%0d", $time, 1_000_000);
        $fatal(1, "watchdog expired");
    end

endmodule
